// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: bit-serial address/write-data in,
// local word memory, bit-serial read data out with optional split.
module serial_slave_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 4,
  parameter int SPLIT_EN     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  output logic slave_ready,
  output logic rd_bus,
  output logic slave_valid,
  input  logic master_ready,
  output logic split
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int LW    = $clog2(READ_LATENCY + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] L_LAST = LW'(READ_LATENCY - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RWAIT = 3'd4;
  localparam logic [2:0] RDATA = 3'd5;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [LW-1:0]         lat;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mode_q;
  logic                  in_acc;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  assign slave_ready = !rst &&
                       ((state == IDLE) ||
                        (state == ADDR) ||
                        (state == WDATA));
  assign in_acc      = master_valid && slave_ready;
  assign slave_valid = (state == RDATA);
  assign rd_bus      = slave_valid && rdata[DATA_WIDTH-1];
  assign split       = (SPLIT_EN != 0) && (state == RWAIT);
  assign addr_nxt    = {addr[ADDR_WIDTH-2:0], wr_bus};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lat    <= '0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      mode_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_acc) begin
            addr   <= addr_nxt;
            mode_q <= mode;
            cnt    <= CW'(1);
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (in_acc) begin
            addr <= addr_nxt;
            if (cnt == A_LAST) begin
              cnt <= '0;
              lat <= '0;
              if (mode_q) begin
                state <= WDATA;
              end else begin
                // fetch uses the address completed by this very bit
                rdata <= mem[addr_nxt];
                state <= RWAIT;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WDATA: begin
          if (in_acc) begin
            wdata <= {wdata[DATA_WIDTH-2:0], wr_bus};
            if (cnt == D_LAST) begin
              cnt   <= '0;
              state <= WRITE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        RWAIT: begin
          if (lat == L_LAST) begin
            lat   <= '0;
            state <= RDATA;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        RDATA: begin
          if (master_ready) begin
            rdata <= {rdata[DATA_WIDTH-2:0], 1'b0};
            if (cnt == D_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // memory is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: vector table of writes/reads
// plus stall, reset, split-disable, back-to-back and mode-glitch cases.
module tb_serial_slave_port;

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [7:0]  d;
  } vec_t;

  logic clk = 1'b0;
  logic rst, mode, wr_bus, master_valid, master_ready;
  logic slave_ready, rd_bus, slave_valid, split;
  logic slave_ready2, rd_bus2, slave_valid2, split2;

  int cyc = 0;
  int pass_cnt = 0;
  int chk_cnt = 0;

  logic       mon_clr = 1'b0;
  logic [7:0] rd2_sh = '0;
  int         rd2_n = 0;
  int         sv2_rise = -1;
  logic       sv2_q = 1'b0;
  int         sp2_total = 0;

  serial_slave_port dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .rd_bus(rd_bus), .slave_valid(slave_valid),
    .master_ready(master_ready), .split(split)
  );

  serial_slave_port #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8),
    .READ_LATENCY(1), .SPLIT_EN(0)
  ) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready2),
    .rd_bus(rd_bus2), .slave_valid(slave_valid2),
    .master_ready(master_ready), .split(split2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (split2) sp2_total <= sp2_total + 1;
  end

  always @(posedge clk) begin
    if (mon_clr) begin
      rd2_sh   <= '0;
      rd2_n    <= 0;
      sv2_rise <= -1;
      sv2_q    <= 1'b0;
    end else begin
      sv2_q <= slave_valid2;
      if (slave_valid2 && !sv2_q && sv2_rise < 0) sv2_rise <= cyc;
      if (slave_valid2 && master_ready) begin
        rd2_sh <= {rd2_sh[6:0], rd_bus2};
        rd2_n  <= rd2_n + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
  endtask

  task automatic send_bit(input logic b, input bit stall);
    if (stall) begin
      master_valid = 1'b0;
      @(negedge clk);
    end
    wr_bus = b;
    master_valid = 1'b1;
    @(negedge clk);
    master_valid = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d,
                          input bit stall,
                          output int total, output int wc);
    int t0;
    int g;
    t0 = cyc;
    chk("w_start_ready", int'(slave_ready), 1);
    mode = 1'b1;
    for (int i = 11; i >= 0; i--) send_bit(a[i], stall);
    for (int i = 7; i >= 0; i--) send_bit(d[i], stall);
    wc = 0;
    g = 0;
    while (!slave_ready && g < 10) begin
      wc++;
      g++;
      @(negedge clk);
    end
    total = cyc - t0;
  endtask

  task automatic do_read(input logic [11:0] a, input bit toggle,
                         input bit glitch, output logic [7:0] d,
                         output int splits, output int lat,
                         output int nbits, output int t_addr);
    int   g;
    int   fv;
    bit   held;
    logic hv;
    d = '0;
    splits = 0;
    nbits = 0;
    held = 1'b0;
    hv = 1'b0;
    fv = -1;
    g = 0;
    mode = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      send_bit(a[i], 1'b0);
      if (glitch) mode = 1'b1;
    end
    t_addr = cyc;
    while (nbits < 8 && g < 200) begin
      if (split) splits++;
      if (slave_valid && fv < 0) fv = cyc;
      if (held && slave_valid) chk("r_hold", int'(rd_bus), int'(hv));
      held = 1'b0;
      master_ready = toggle ? ((g % 2) != 0) : 1'b1;
      if (slave_valid && master_ready) begin
        d = {d[6:0], rd_bus};
        nbits++;
      end else if (slave_valid) begin
        held = 1'b1;
        hv = rd_bus;
      end
      @(negedge clk);
      g++;
    end
    master_ready = 1'b0;
    mode = 1'b0;
    lat = fv - t_addr;
    chk("r_end_valid", int'(slave_valid), 0);
    chk("r_end_rd_bus", int'(rd_bus), 0);
    chk("r_end_split", int'(split), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[9];
    int          tot, wc, sp, lat, n, ta;
    logic [7:0]  rd;
    logic [11:0] av;
    logic [7:0]  dv;

    tv[0] = '{1'b1, 12'h05A, 8'hC3};
    tv[1] = '{1'b0, 12'h05A, 8'hC3};
    tv[2] = '{1'b1, 12'h100, 8'hAA};
    tv[3] = '{1'b1, 12'h101, 8'h55};
    tv[4] = '{1'b0, 12'h100, 8'hAA};
    tv[5] = '{1'b0, 12'h101, 8'h55};
    tv[6] = '{1'b1, 12'h001, 8'h7E};
    tv[7] = '{1'b1, 12'h010, 8'h55};
    tv[8] = '{1'b1, 12'h0AB, 8'h3C};

    rst = 1'b1;
    mode = 1'b0;
    wr_bus = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_slave_ready", int'(slave_ready), 0);
    chk("rst_slave_valid", int'(slave_valid), 0);
    chk("rst_rd_bus", int'(rd_bus), 0);
    chk("rst_split", int'(split), 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", int'(slave_ready), 1);

    for (int i = 0; i < 9; i++) begin
      if (tv[i].wr) begin
        do_write(tv[i].a, tv[i].d, 1'b0, tot, wc);
        chk("tbl_w_cycles", tot, 21);
        chk("tbl_w_write_state", wc, 1);
      end else begin
        do_read(tv[i].a, 1'b0, 1'b0, rd, sp, lat, n, ta);
        chk("tbl_r_data", int'(rd), int'(tv[i].d));
        chk("tbl_r_bits", n, 8);
        chk("tbl_r_split_cycles", sp, 4);
        chk("tbl_r_latency", lat, 4);
      end
    end

    do_write(12'hFFF, 8'h81, 1'b1, tot, wc);
    chk("stall_w_cycles", tot, 41);
    chk("stall_w_write_state", wc, 1);
    do_read(12'hFFF, 1'b1, 1'b0, rd, sp, lat, n, ta);
    chk("stall_r_data", int'(rd), 8'h81);
    chk("stall_r_bits", n, 8);
    chk("stall_r_split_cycles", sp, 4);

    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    do_read(12'h001, 1'b0, 1'b0, rd, sp, lat, n, ta);
    chk("lat1_main_data", int'(rd), 8'h7E);
    chk("lat1_data", int'(rd2_sh), 8'h7E);
    chk("lat1_bits", rd2_n, 8);
    chk("lat1_valid_rise", sv2_rise - ta, 1);

    av = 12'h010;
    dv = 8'hAA;
    mode = 1'b1;
    for (int i = 11; i >= 0; i--) send_bit(av[i], 1'b0);
    for (int i = 7; i >= 3; i--) send_bit(dv[i], 1'b0);
    chk("midw_ready_before", int'(slave_ready), 1);
    rst = 1'b1;
    #1;
    chk("midw_ready_async", int'(slave_ready), 0);
    chk("midw_valid_async", int'(slave_valid), 0);
    chk("midw_rd_bus_async", int'(rd_bus), 0);
    chk("midw_split_async", int'(split), 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 1'b0;
    do_read(12'h010, 1'b0, 1'b0, rd, sp, lat, n, ta);
    chk("midw_readback", int'(rd), 8'h55);

    av = 12'h05A;
    mode = 1'b0;
    for (int i = 11; i >= 0; i--) send_bit(av[i], 1'b0);
    chk("rwait_split_on", int'(split), 1);
    rst = 1'b1;
    #1;
    chk("rwait_split_async", int'(split), 0);
    chk("rwait_ready_async", int'(slave_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    do_read(12'h05A, 1'b0, 1'b0, rd, sp, lat, n, ta);
    chk("rwait_readback", int'(rd), 8'hC3);

    do_read(12'h0AB, 1'b0, 1'b1, rd, sp, lat, n, ta);
    chk("glitch_data", int'(rd), 8'h3C);
    chk("glitch_split_cycles", sp, 4);
    do_read(12'h0AB, 1'b0, 1'b0, rd, sp, lat, n, ta);
    chk("glitch_no_write", int'(rd), 8'h3C);

    chk("split_disabled_total", sp2_total, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
